peak_finder: RTL and testbench
==============================

PEAK_FINDER -- requirements
Module: peak_finder

Interface
REQ-001 Parameter DATA_WIDTH, default SIZE_FILTER_DATA (package_settings), width of the filter sample and of the amplitude.
REQ-002 Parameter TIME_WIDTH, default 16, width of the free-running timestamp counter.
REQ-003 Parameter DEAD_TIME, default 4, number of clock cycles after an emitted peak during which arming is blocked (valid range 1..255).
REQ-004 Parameter MAX_WIDTH, default 64, maximum number of consecutive above-threshold samples before forced emission (valid range 2..255).
REQ-005 The port clk SHALL be an input, 1 bit wide, and is the single clock; all logic SHALL be on its rising edge.
REQ-006 The port reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-007 The port input_data SHALL be an input, DATA_WIDTH bits wide, carrying the unsigned filter output, one new sample every clock.
REQ-008 The port threshold SHALL be an input, DATA_WIDTH bits wide, unsigned, and SHALL be sampled every clock.
REQ-009 The port peak_valid SHALL be an output, 1 bit wide, pulsing for one cycle per emitted peak.
REQ-010 The port peak_amplitude SHALL be an output, DATA_WIDTH bits wide, holding the maximum sample of the pulse.
REQ-011 The port peak_time SHALL be an output, TIME_WIDTH bits wide, holding the timestamp of the maximum sample.
REQ-012 The port peak_overflow SHALL be an output, 1 bit wide, set when the emission was forced by MAX_WIDTH.
REQ-013 The port event_count SHALL be an output, 16 bits wide, counting emitted peaks and saturating at 0xFFFF.

Function
REQ-014 input_data and threshold SHALL be registered once (sample_r, thr_r); the timestamp of sample_r SHALL be the time counter value on the edge that captured it.
REQ-015 The time counter SHALL increment by 1 every clock and wrap from 2^TIME_WIDTH-1 to 0 with no flag.
REQ-016 The FSM SHALL have the states IDLE, ABOVE, WAIT_LOW and DEAD.
REQ-017 In IDLE, if sample_r > thr_r, the FSM SHALL go to ABOVE, load max=sample_r, load max_time=its timestamp, and set width=1.
REQ-018 In ABOVE, if sample_r > max, the FSM SHALL update max and max_time; if sample_r == max, it SHALL keep the earlier max_time.
REQ-019 In ABOVE, if sample_r <= thr_r, the FSM SHALL emit (peak_overflow=0) and go to DEAD; otherwise it SHALL increment width.
REQ-020 In ABOVE, when width reaches MAX_WIDTH with sample_r still > thr_r, the FSM SHALL emit (peak_overflow=1) and go to WAIT_LOW.
REQ-021 WAIT_LOW SHALL ignore samples until sample_r <= thr_r, then go to DEAD without emitting.
REQ-022 DEAD SHALL count DEAD_TIME cycles, then go to IDLE; samples in DEAD SHALL be ignored even if above threshold.
REQ-023 An emission SHALL register peak_amplitude=max, peak_time=max_time and peak_overflow, SHALL assert peak_valid for exactly one cycle, and SHALL increment event_count unless it is 0xFFFF.
REQ-024 peak_amplitude, peak_time and peak_overflow SHALL hold their values until the next emission.
REQ-025 Latency SHALL be that peak_valid is high in the cycle after the edge at which the FSM evaluates the terminating sample_r, i.e. 2 edges after input_data presents that sample.
REQ-026 Comparisons SHALL be unsigned at full DATA_WIDTH; sample == threshold SHALL count as below.
REQ-027 A threshold change mid-pulse SHALL take effect on the next thr_r evaluation, with no other side effect.

Reset
REQ-028 While reset=1 at an edge: FSM=IDLE; sample_r, thr_r, time counter, max, max_time, width and dead counter SHALL be 0; peak_valid=0, peak_amplitude=0, peak_time=0, peak_overflow=0, event_count=0.
REQ-029 A reset asserted mid-pulse SHALL abandon the pulse with no emission; the first sample evaluated after release SHALL be treated from IDLE.

Verification (DATA_WIDTH=16, TIME_WIDTH=16, DEAD_TIME=4, MAX_WIDTH=8, threshold=100)
REQ-030 Single pulse: input 50,120,300,250,90 starting at t=10 -> one peak_valid, amplitude=300, peak_time=12, overflow=0, event_count=1, valid 2 edges after sample 90.
REQ-031 Tie plus exact-threshold case: input 200,200,100 -> amplitude=200, peak_time = timestamp of the first 200; sample 100 terminates the pulse.
REQ-032 Overflow case: input above 100 for 20 cycles with max 500 in cycle 3 -> emission after 8 samples with amplitude=500 and overflow=1; no second emission until input drops <=100 and 4 dead cycles pass.
REQ-033 Dead time: second pulse starting 2 cycles after the end of the first -> ignored; a pulse starting 6 cycles after -> emitted, event_count=2.
REQ-034 Reset mid-pulse plus wrap: reset during ABOVE -> no emission and all outputs 0; a pulse spanning time counter 0xFFFF->0 -> correct wrapped peak_time.
REQ-035 Saturation: event_count forced via 65536 pulses -> event_count stays at 0xFFFF while peak_valid still pulses.

Source files
------------

// File: rtl/peak_finder.sv
// ---------------------------------------------------------------------------
// peak_finder
//   Detects pulses in a stream of unsigned filter samples. A pulse starts
//   when a registered sample rises above the registered threshold and ends
//   when a sample falls back to or below it. For each pulse the maximum
//   sample and the timestamp of its first occurrence are reported. Pulses
//   longer than MAX_WIDTH samples are cut short and flagged. After every
//   pulse a dead period of DEAD_TIME samples blocks re-arming.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high
//   input_data     : unsigned filter sample, one per clock
//   threshold      : unsigned arming threshold, sampled every clock
//   peak_valid     : one-cycle pulse per emitted peak
//   peak_amplitude : maximum sample of the last emitted pulse (held)
//   peak_time      : timestamp of that maximum (held)
//   peak_overflow  : last emission was forced by MAX_WIDTH (held)
//   event_count    : number of emitted peaks, saturating at 0xFFFF
// ---------------------------------------------------------------------------
package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

module peak_finder #(
    parameter int DATA_WIDTH = package_settings::SIZE_FILTER_DATA,
    parameter int TIME_WIDTH = 16,
    parameter int DEAD_TIME  = 4,   // 1..255
    parameter int MAX_WIDTH  = 64   // 2..255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  peak_valid,
    output logic [DATA_WIDTH-1:0] peak_amplitude,
    output logic [TIME_WIDTH-1:0] peak_time,
    output logic                  peak_overflow,
    output logic [15:0]           event_count
);

    typedef enum logic [1:0] {
        IDLE,
        ABOVE,
        WAIT_LOW,
        DEAD
    } state_t;

    // Width counter value seen while evaluating the MAX_WIDTH-th sample.
    localparam logic [7:0] WIDTH_LAST = 8'(MAX_WIDTH - 1);
    localparam logic [7:0] DEAD_LAST  = 8'(DEAD_TIME - 1);

    state_t                state_r, state_next;
    logic [DATA_WIDTH-1:0] sample_r, thr_r;
    logic [TIME_WIDTH-1:0] time_r, sample_time_r;
    logic [DATA_WIDTH-1:0] max_r, max_next;
    logic [TIME_WIDTH-1:0] max_time_r, max_time_next;
    logic [7:0]            width_r, width_next;
    logic [7:0]            dead_r, dead_next;
    logic [15:0]           event_cnt_r, event_cnt_next;
    logic                  emit, emit_ovf;
    logic                  above;

    // Equality with the threshold counts as below.
    assign above       = sample_r > thr_r;
    assign event_count = event_cnt_r;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next     = state_r;
        max_next       = max_r;
        max_time_next  = max_time_r;
        width_next     = width_r;
        dead_next      = dead_r;
        emit           = 1'b0;
        emit_ovf       = 1'b0;

        case (state_r)
            IDLE: begin
                if (above) begin
                    state_next    = ABOVE;
                    max_next      = sample_r;
                    max_time_next = sample_time_r;
                    width_next    = 8'd1;
                end
            end
            ABOVE: begin
                if (!above) begin
                    emit       = 1'b1;
                    state_next = DEAD;
                    dead_next  = 8'd0;
                end else begin
                    // Strict compare: a tie keeps the earlier timestamp.
                    if (sample_r > max_r) begin
                        max_next      = sample_r;
                        max_time_next = sample_time_r;
                    end
                    if (width_r == WIDTH_LAST) begin
                        // This sample is the MAX_WIDTH-th one; it is already
                        // folded into max_next, so emit the updated maximum.
                        emit       = 1'b1;
                        emit_ovf   = 1'b1;
                        state_next = WAIT_LOW;
                    end else begin
                        width_next = width_r + 8'd1;
                    end
                end
            end
            WAIT_LOW: begin
                if (!above) begin
                    state_next = DEAD;
                    dead_next  = 8'd0;
                end
            end
            DEAD: begin
                if (dead_r == DEAD_LAST) begin
                    state_next = IDLE;
                end else begin
                    dead_next = dead_r + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        event_cnt_next = event_cnt_r;
        if (emit && (event_cnt_r != 16'hFFFF)) begin
            event_cnt_next = event_cnt_r + 16'd1;
        end
    end

    // NOTE: non-blocking assignments so every register samples the values
    // that existed before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            sample_r       <= '0;
            thr_r          <= '0;
            time_r         <= '0;
            sample_time_r  <= '0;
            max_r          <= '0;
            max_time_r     <= '0;
            width_r        <= '0;
            dead_r         <= '0;
            event_cnt_r    <= '0;
            peak_valid     <= 1'b0;
            peak_amplitude <= '0;
            peak_time      <= '0;
            peak_overflow  <= 1'b0;
        end else begin
            // The timestamp of a sample is the counter value on the edge
            // that captures it; the counter wraps silently.
            sample_r       <= input_data;
            thr_r          <= threshold;
            sample_time_r  <= time_r;
            time_r         <= time_r + TIME_WIDTH'(1);
            state_r        <= state_next;
            max_r          <= max_next;
            max_time_r     <= max_time_next;
            width_r        <= width_next;
            dead_r         <= dead_next;
            event_cnt_r    <= event_cnt_next;
            peak_valid     <= emit;
            if (emit) begin
                peak_amplitude <= max_next;
                peak_time      <= max_time_next;
                peak_overflow  <= emit_ovf;
            end
        end
    end

endmodule

// File: tb/tb_peak_finder.sv
// ---------------------------------------------------------------------------
// tb_peak_finder
//   Self-checking bench for peak_finder (DATA_WIDTH=16, TIME_WIDTH=16,
//   DEAD_TIME=4, MAX_WIDTH=8). Directed vectors from a table, hand-written
//   sequences for reset mid-pulse and counter saturation, and a long random
//   stream (crossing the timestamp wrap) checked cycle by cycle against a
//   pulse-segmentation reference model.
// ---------------------------------------------------------------------------
module tb_peak_finder;

    localparam int DW = 16;
    localparam int TW = 16;
    localparam int DT = 4;
    localparam int MW = 8;
    localparam int NV = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] input_data = '0;
    logic [DW-1:0] threshold = '0;
    logic          peak_valid;
    logic [DW-1:0] peak_amplitude;
    logic [TW-1:0] peak_time;
    logic          peak_overflow;
    logic [15:0]   event_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus stream and per-cycle observations (index = sample index).
    logic [15:0] stim_d[$], stim_t[$];
    logic        obs_v[$], obs_o[$];
    logic [15:0] obs_a[$], obs_ts[$], obs_c[$];

    // Reference model output: one entry per expected emission.
    int          em_idx[$];
    logic [15:0] em_amp[$], em_ts[$];
    logic        em_ovf[$];

    typedef struct {
        int          thr;
        int          d[24];
        int          n_ev;
        logic [15:0] amp;
        logic [15:0] ts;
        logic        ovf;
        logic [15:0] cnt;
        int          vc;     // cycle in which the last peak_valid is expected
    } vec_t;

    vec_t vecs[NV];

    peak_finder #(
        .DATA_WIDTH(DW),
        .TIME_WIDTH(TW),
        .DEAD_TIME (DT),
        .MAX_WIDTH (MW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_data    (input_data),
        .threshold     (threshold),
        .peak_valid    (peak_valid),
        .peak_amplitude(peak_amplitude),
        .peak_time     (peak_time),
        .peak_overflow (peak_overflow),
        .event_count   (event_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int thr, int n_ev, int amp, int ts, int ovf, int cnt, int vc);
        vec_t v;
        v.thr  = thr;
        for (int i = 0; i < 24; i++) v.d[i] = 0;
        v.n_ev = n_ev;
        v.amp  = 16'(amp);
        v.ts   = 16'(ts);
        v.ovf  = ovf[0];
        v.cnt  = 16'(cnt);
        v.vc   = vc;
        return v;
    endfunction

    // Drive one sample right after an edge, record outputs mid-cycle.
    task automatic drive(input logic [15:0] d, input logic [15:0] t);
        input_data = d;
        threshold  = t;
        @(negedge clk);
        obs_v.push_back(peak_valid);
        obs_a.push_back(peak_amplitude);
        obs_ts.push_back(peak_time);
        obs_o.push_back(peak_overflow);
        obs_c.push_back(event_count);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        input_data = '0;
        threshold  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(peak_valid), 64'd0);
        check("rst_amp",   64'(peak_amplitude), 64'd0);
        check("rst_time",  64'(peak_time), 64'd0);
        check("rst_ovf",   64'(peak_overflow), 64'd0);
        check("rst_count", 64'(event_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_v.delete(); obs_a.delete(); obs_ts.delete(); obs_o.delete(); obs_c.delete();
    endtask

    // Segment the stream into pulses: a run of above-threshold samples,
    // capped at MW samples, followed by DT ignored samples after its end.
    task automatic run_model();
        int n;
        int i;
        n = stim_d.size();
        i = 0;
        em_idx.delete(); em_amp.delete(); em_ts.delete(); em_ovf.delete();
        while (i < n) begin
            if (stim_d[i] > stim_t[i]) begin
                logic [15:0] amp;
                int ts, len, j;
                amp = stim_d[i]; ts = i; len = 1; j = i + 1;
                while (j < n && len < MW && stim_d[j] > stim_t[j]) begin
                    if (stim_d[j] > amp) begin
                        amp = stim_d[j];
                        ts  = j;
                    end
                    len++;
                    j++;
                end
                if (len == MW) begin
                    em_idx.push_back(j - 1); em_amp.push_back(amp);
                    em_ts.push_back(16'(ts)); em_ovf.push_back(1'b1);
                    while (j < n && stim_d[j] > stim_t[j]) j++;
                    i = j + 1 + DT;
                end else if (j < n) begin
                    em_idx.push_back(j); em_amp.push_back(amp);
                    em_ts.push_back(16'(ts)); em_ovf.push_back(1'b0);
                    i = j + 1 + DT;
                end else begin
                    i = n;
                end
            end else begin
                i++;
            end
        end
    endtask

    // Expected outputs per cycle: valid two cycles after the terminating
    // sample, other outputs held from the most recent emission.
    task automatic compare_stream();
        int          p;
        logic [15:0] ha, ht, hc;
        logic        ho, ev;
        p = 0; ha = '0; ht = '0; hc = '0; ho = 1'b0;
        run_model();
        for (int c = 0; c < obs_v.size(); c++) begin
            ev = 1'b0;
            if (p < em_idx.size() && em_idx[p] + 2 == c) begin
                ev = 1'b1;
                ha = em_amp[p];
                ht = em_ts[p];
                ho = em_ovf[p];
                if (hc != 16'hFFFF) hc = hc + 16'd1;
                p++;
            end
            check($sformatf("out@%0d{v,amp,time,ovf,cnt}", c),
                  64'({obs_v[c], obs_a[c], obs_ts[c], obs_o[c], obs_c[c]}),
                  64'({ev, ha, ht, ho, hc}));
        end
        check("model_emits_reached", 64'(p), 64'(em_idx.size()));
    endtask

    task automatic run_stream();
        apply_reset();
        for (int k = 0; k < stim_d.size(); k++) drive(stim_d[k], stim_t[k]);
        compare_stream();
    endtask

    initial begin
        int          nv, vc;
        logic [15:0] prev, expc;
        int          thr;
        bit          hi;

        // ---------------- directed table ----------------
        vecs[0] = mk(100, 1, 300, 12, 0, 1, 16);      // single pulse at t=10
        vecs[0].d[10] = 50;  vecs[0].d[11] = 120; vecs[0].d[12] = 300;
        vecs[0].d[13] = 250; vecs[0].d[14] = 90;
        vecs[1] = mk(100, 1, 200, 0, 0, 1, 4);        // tie, exact-threshold end
        vecs[1].d[0] = 200; vecs[1].d[1] = 200; vecs[1].d[2] = 100;
        vecs[2] = mk(100, 1, 101, 2, 0, 1, 5);        // equality does not arm
        vecs[2].d[0] = 100; vecs[2].d[1] = 100; vecs[2].d[2] = 101; vecs[2].d[3] = 50;
        vecs[3] = mk(100, 1, 150, 0, 0, 1, 3);        // pulse inside dead time
        vecs[3].d[0] = 150; vecs[3].d[1] = 50; vecs[3].d[3] = 180; vecs[3].d[4] = 170;
        vecs[4] = mk(100, 2, 180, 7, 0, 2, 10);       // pulse after dead time
        vecs[4].d[0] = 150; vecs[4].d[1] = 50; vecs[4].d[7] = 180; vecs[4].d[8] = 50;
        vecs[5] = mk(100, 1, 500, 2, 1, 1, 9);        // forced emission
        vecs[5].d[0] = 150; vecs[5].d[1] = 160; vecs[5].d[2] = 500;
        for (int i = 3; i < 20; i++) vecs[5].d[i] = 200;
        vecs[5].d[20] = 50;
        vecs[6] = mk(16'hFFFE, 1, 16'hFFFF, 0, 0, 1, 3); // full-width compare
        vecs[6].d[0] = 16'hFFFF; vecs[6].d[1] = 16'hFFFE;
        vecs[7] = mk(100, 1, 170, 6, 0, 1, 9);        // MW-1 samples: normal
        for (int i = 0; i < 7; i++) vecs[7].d[i] = 110 + 10 * i;
        vecs[8] = mk(100, 1, 180, 7, 1, 1, 9);        // exactly MW samples
        for (int i = 0; i < 8; i++) vecs[8].d[i] = 110 + 10 * i;

        for (int r = 0; r < NV; r++) begin
            stim_d.delete(); stim_t.delete();
            for (int i = 0; i < 24; i++) begin
                stim_d.push_back(16'(vecs[r].d[i]));
                stim_t.push_back(16'(vecs[r].thr));
            end
            for (int i = 0; i < 12; i++) begin
                stim_d.push_back(16'd0);
                stim_t.push_back(16'(vecs[r].thr));
            end
            run_stream();
            nv = 0;
            foreach (obs_v[c]) if (obs_v[c]) nv++;
            vc = vecs[r].vc;
            check($sformatf("row%0d_events", r), 64'(nv), 64'(vecs[r].n_ev));
            check($sformatf("row%0d_valid", r), 64'(obs_v[vc]), 64'd1);
            check($sformatf("row%0d_pulse_len", r), 64'(obs_v[vc+1]), 64'd0);
            check($sformatf("row%0d_amp", r), 64'(obs_a[vc]), 64'(vecs[r].amp));
            check($sformatf("row%0d_time", r), 64'(obs_ts[vc]), 64'(vecs[r].ts));
            check($sformatf("row%0d_ovf", r), 64'(obs_o[vc]), 64'(vecs[r].ovf));
            check($sformatf("row%0d_count", r), 64'(obs_c[vc]), 64'(vecs[r].cnt));
        end

        // ---------------- reset in the middle of a pulse ----------------
        apply_reset();
        drive(16'd300, 16'd100);
        drive(16'd50, 16'd100);
        repeat (6) drive(16'd0, 16'd100);
        drive(16'd150, 16'd100);
        drive(16'd200, 16'd100);
        check("pre_rst_valid", 64'(obs_v[3]), 64'd1);
        check("pre_rst_amp_held", 64'(obs_a[9]), 64'd300);
        stim_d.delete(); stim_t.delete();
        stim_d.push_back(16'd150); stim_t.push_back(16'd100);
        stim_d.push_back(16'd50);  stim_t.push_back(16'd100);
        repeat (12) begin stim_d.push_back(16'd0); stim_t.push_back(16'd100); end
        run_stream();
        check("post_rst_valid", 64'(obs_v[3]), 64'd1);
        check("post_rst_amp", 64'(obs_a[3]), 64'd150);
        check("post_rst_time", 64'(obs_ts[3]), 64'd0);
        check("post_rst_count", 64'(obs_c[3]), 64'd1);

        // ---------------- event counter saturation ----------------
        apply_reset();
        repeat (2) drive(16'd0, 16'd100);
        force dut.event_cnt_r = 16'hFFFD;
        drive(16'd0, 16'd100);
        release dut.event_cnt_r;
        for (int p = 0; p < 4; p++) begin
            drive(16'd200, 16'd100);
            drive(16'd50, 16'd100);
            repeat (5) drive(16'd0, 16'd100);
        end
        repeat (3) drive(16'd0, 16'd100);
        prev = 16'hFFFD;
        for (int p = 0; p < 4; p++) begin
            expc = (prev == 16'hFFFF) ? prev : prev + 16'd1;
            check($sformatf("sat%0d_before", p), 64'(obs_c[5 + 7*p]), 64'(prev));
            check($sformatf("sat%0d_valid", p), 64'(obs_v[6 + 7*p]), 64'd1);
            check($sformatf("sat%0d_count", p), 64'(obs_c[6 + 7*p]), 64'(expc));
            check($sformatf("sat%0d_pulse_len", p), 64'(obs_v[7 + 7*p]), 64'd0);
            prev = expc;
        end

        // ---------------- random stream across the timestamp wrap -------
        stim_d.delete(); stim_t.delete();
        thr = 100;
        hi  = 1'b0;
        for (int i = 0; i < 65520; i++) begin
            if ($urandom_range(0, 49) == 0) thr = int'($urandom_range(60, 160));
            if ($urandom_range(0, 3) == 0) hi = !hi;
            if ($urandom_range(0, 9) == 0)
                stim_d.push_back(16'(thr));
            else if (hi)
                stim_d.push_back(16'(thr + 10 * int'($urandom_range(0, 30))));
            else
                stim_d.push_back(16'($urandom_range(0, thr)));
            stim_t.push_back(16'(thr));
        end
        repeat (14) begin stim_d.push_back(16'd0); stim_t.push_back(16'd100); end
        stim_d.push_back(16'd150); stim_t.push_back(16'd100);   // t = 0xFFFE
        stim_d.push_back(16'd160); stim_t.push_back(16'd100);   // t = 0xFFFF
        stim_d.push_back(16'd400); stim_t.push_back(16'd100);   // t = 0x0000
        stim_d.push_back(16'd120); stim_t.push_back(16'd100);
        stim_d.push_back(16'd50);  stim_t.push_back(16'd100);
        repeat (12) begin stim_d.push_back(16'd0); stim_t.push_back(16'd100); end
        run_stream();
        check("wrap_valid", 64'(obs_v[65540]), 64'd1);
        check("wrap_amp", 64'(obs_a[65540]), 64'd400);
        check("wrap_time", 64'(obs_ts[65540]), 64'd0);
        check("wrap_ovf", 64'(obs_o[65540]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
